pc_unit: RTL and testbench

Parametrised program-counter unit for the multi-cycle MIPS core, successor to the current single-register PC. It holds the architectural PC and performs sequential increments. It schedules taken branches and jumps through an explicit delay-slot state machine, so the controller never has to time a target write against a particular FSM state. It also adds halt detection, target alignment checking and a link-address output.

---
 rtl/pc_unit.sv | 144 ++++++++++++++
 tb/tb_pc_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: architectural PC with sequential increment, delay-slot
// branch scheduling, halt detection, target alignment checking and link address.
module pc_unit #(
    parameter int unsigned WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
    parameter int unsigned STEP         = 4,
    parameter int unsigned ALIGN_BITS   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             inc,
    input  logic             branch_req,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_link,
    output logic             active,
    output logic             branch_pending,
    output logic             in_delay_slot,
    output logic             fault
);

    localparam logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] HALT_PC    = WIDTH'(HALT_ADDR);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LINK_W     = WIDTH'(2 * STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~({WIDTH{1'b1}} << ALIGN_BITS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_SLOT   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_target;
    logic             r_active;
    logic             r_branch_pending;
    logic             r_in_delay_slot;
    logic             r_fault;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_target_next;
    logic             w_fault_next;
    logic             w_pc_load;
    logic             w_misaligned;

    assign w_misaligned = (target & ALIGN_MASK) != '0;

    // State register; stall freezes everything by holding next == current.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_pc             <= RESET_PC;
            r_target         <= '0;
            r_active         <= 1'b1;
            r_branch_pending <= 1'b0;
            r_in_delay_slot  <= 1'b0;
            r_fault          <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_pc             <= w_pc_next;
            r_target         <= w_target_next;
            r_active         <= (w_state_next != S_HALTED);
            r_branch_pending <= (w_state_next != S_IDLE);
            r_in_delay_slot  <= (w_state_next == S_SLOT);
            r_fault          <= w_fault_next;
        end
    end

    // Next-state and PC update logic.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_target_next = r_target;
        w_fault_next  = r_fault;
        w_pc_load     = 1'b0;

        if (!stall) begin
            unique case (r_state)
                S_IDLE: begin
                    if (branch_req && w_misaligned) begin
                        w_fault_next = 1'b1;
                        if (inc) begin
                            w_pc_next = r_pc + STEP_W;
                            w_pc_load = 1'b1;
                        end
                    end else if (branch_req) begin
                        w_target_next = target;
                        if (inc) begin
                            w_pc_next    = r_pc + STEP_W;
                            w_pc_load    = 1'b1;
                            w_state_next = S_SLOT;
                        end else begin
                            w_state_next = S_ARMED;
                        end
                    end else if (inc) begin
                        w_pc_next = r_pc + STEP_W;
                        w_pc_load = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (branch_req) w_fault_next = 1'b1;
                    if (inc) begin
                        w_pc_next    = r_pc + STEP_W;
                        w_pc_load    = 1'b1;
                        w_state_next = S_SLOT;
                    end
                end
                S_SLOT: begin
                    if (branch_req) w_fault_next = 1'b1;
                    if (inc) begin
                        w_pc_next    = r_target;
                        w_pc_load    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                S_HALTED: begin
                    w_state_next = S_HALTED;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase

            // Reaching the halt address by any path stops the core on the same edge.
            if (w_pc_load && (w_pc_next == HALT_PC)) begin
                w_state_next = S_HALTED;
            end
        end
    end

    assign pc             = r_pc;
    assign pc_link        = r_pc + LINK_W;
    assign active         = r_active;
    assign branch_pending = r_branch_pending;
    assign in_delay_slot  = r_in_delay_slot;
    assign fault          = r_fault;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        inc;
    logic        branch_req;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_link;
    logic        active;
    logic        branch_pending;
    logic        in_delay_slot;
    logic        fault;

    int n_checks;
    int n_pass;

    pc_unit dut (
        .clk            (clk),
        .reset          (rst_n),
        .stall          (stall),
        .inc            (inc),
        .branch_req     (branch_req),
        .target         (target),
        .pc             (pc),
        .pc_link        (pc_link),
        .active         (active),
        .branch_pending (branch_pending),
        .in_delay_slot  (in_delay_slot),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Present a one-cycle request from one falling edge to the next.
    task automatic pulse(input logic i_inc, input logic i_br, input logic [31:0] i_tgt);
        @(negedge clk);
        inc        = i_inc;
        branch_req = i_br;
        target     = i_tgt;
        @(negedge clk);
        inc        = 1'b0;
        branch_req = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic e_act, input logic e_bp,
                               input logic e_ds, input logic e_flt);
        check({tag, ".active"}, 32'(active), 32'(e_act));
        check({tag, ".bp"},     32'(branch_pending), 32'(e_bp));
        check({tag, ".ds"},     32'(in_delay_slot), 32'(e_ds));
        check({tag, ".fault"},  32'(fault), 32'(e_flt));
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        stall      = 1'b0;
        inc        = 1'b0;
        branch_req = 1'b0;
        target     = '0;
        rst_n      = 1'b0;
        #12;
        check("rst.pc", pc, 32'hBFC0_0000);
        check("rst.link", pc_link, 32'hBFC0_0008);
        check_flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential increments
        pulse(1'b1, 1'b0, 32'h0);
        check("inc1.pc", pc, 32'hBFC0_0004);
        pulse(1'b1, 1'b0, 32'h0);
        check("inc2.pc", pc, 32'hBFC0_0008);
        pulse(1'b1, 1'b0, 32'h0);
        check("inc3.pc", pc, 32'hBFC0_000C);
        check("inc3.link", pc_link, 32'hBFC0_0014);
        check("inc3.active", 32'(active), 32'd1);
        pulse(1'b1, 1'b0, 32'h0);
        check("inc4.pc", pc, 32'hBFC0_0010);

        // Branch with separate inc pulses and an idle gap
        pulse(1'b0, 1'b1, 32'hBFC0_0100);
        check("arm.pc", pc, 32'hBFC0_0010);
        check_flags("arm", 1'b1, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 32'h0);
        check("slot.pc", pc, 32'hBFC0_0014);
        check_flags("slot", 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("gap.pc", pc, 32'hBFC0_0014);
        pulse(1'b1, 1'b0, 32'h0);
        check("take.pc", pc, 32'hBFC0_0100);
        check_flags("take", 1'b1, 1'b0, 1'b0, 1'b0);

        // Misaligned target
        pulse(1'b0, 1'b1, 32'hBFC0_0102);
        check("mis.pc", pc, 32'hBFC0_0100);
        check_flags("mis", 1'b1, 1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 32'h0);
        check("mis_inc.pc", pc, 32'hBFC0_0104);
        check("mis_inc.fault", 32'(fault), 32'd1);

        // Reset clears sticky fault
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst2.pc", pc, 32'hBFC0_0000);
        check("rst2.fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Branch coinciding with inc, then stall holding SLOT
        pulse(1'b1, 1'b1, 32'hBFC0_0200);
        check("bi.pc", pc, 32'hBFC0_0004);
        check_flags("bi", 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        stall      = 1'b1;
        inc        = 1'b1;
        branch_req = 1'b1;
        target     = 32'hBFC0_0300;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall.pc", pc, 32'hBFC0_0004);
        end
        check_flags("stall", 1'b1, 1'b1, 1'b1, 1'b0);
        stall      = 1'b0;
        inc        = 1'b0;
        branch_req = 1'b0;

        // Branch in delay slot faults but the original target is kept
        pulse(1'b0, 1'b1, 32'hBFC0_0300);
        check("dsbr.pc", pc, 32'hBFC0_0004);
        check_flags("dsbr", 1'b1, 1'b1, 1'b1, 1'b1);
        pulse(1'b1, 1'b0, 32'h0);
        check("dstake.pc", pc, 32'hBFC0_0200);
        check_flags("dstake", 1'b1, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset while in SLOT discards the target
        pulse(1'b1, 1'b1, 32'hBFC0_0400);
        check("rs_slot.pc", pc, 32'hBFC0_0204);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async.pc", pc, 32'hBFC0_0000);
        check_flags("rs_async", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse(1'b1, 1'b0, 32'h0);
        check("rs_after.pc", pc, 32'hBFC0_0004);
        pulse(1'b1, 1'b0, 32'h0);
        check("rs_after2.pc", pc, 32'hBFC0_0008);
        check("rs_after2.ds", 32'(in_delay_slot), 32'd0);

        // Jump to halt address
        pulse(1'b1, 1'b1, 32'h0000_0000);
        check("hj.pc", pc, 32'hBFC0_000C);
        check("hj.ds", 32'(in_delay_slot), 32'd1);
        pulse(1'b1, 1'b0, 32'h0);
        check("halt.pc", pc, 32'h0000_0000);
        check("halt.active", 32'(active), 32'd0);
        check("halt.link", pc_link, 32'h0000_0008);
        pulse(1'b1, 1'b0, 32'h0);
        check("halt_inc.pc", pc, 32'h0000_0000);
        pulse(1'b1, 1'b1, 32'h0000_0042);
        check("halt_br.pc", pc, 32'h0000_0000);
        check("halt_br.fault", 32'(fault), 32'd0);
        check("halt_br.active", 32'(active), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
